// File: rtl/stretch_pkg.sv
// Shared encodings for the multi-channel pulse stretcher: edge-mode select,
// channel FSM states and the edge qualification helper.
package stretch_pkg;

    typedef enum logic [1:0] {
        MODE_RISE   = 2'b00,
        MODE_FALL   = 2'b01,
        MODE_BOTH   = 2'b10,
        MODE_BYPASS = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Bypass never qualifies an edge, so a bypassed channel can never enter HOLD.
    function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (mode_e'(mode))
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/stretch_chan.sv
// One stretch channel: input synchroniser, edge detect and the IDLE/HOLD FSM
// with its tick counter. The hold tick, mode and retrigger come from the top.
module stretch_chan
    import stretch_pkg::*;
#(
    parameter int HOLD_TICKS  = 250,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in,
    input  logic       i_tick,
    input  logic [1:0] i_mode,
    input  logic       i_retrig,
    output logic       o_out,
    output logic       o_busy
);

    localparam int            CW       = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TICKS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_e                 r_state;
    logic [CW-1:0]          r_cnt;

    logic w_s;
    logic w_edge;
    logic w_expire;
    logic w_bypass;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_edge   = edge_hit(i_mode, w_s & ~r_prev, ~w_s & r_prev);
    assign w_expire = i_tick && (r_cnt == CNT_LAST);
    assign w_bypass = (mode_e'(i_mode) == MODE_BYPASS);

    // NOTE: every flop here uses <= so all stages sample the pre-edge values;
    // a blocking assignment would collapse the synchroniser into one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_prev <= w_s;
        end
    end

    // An edge coinciding with expiry always wins and restarts the hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            o_out   <= 1'b0;
            o_busy  <= 1'b0;
        end else if (w_bypass) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            o_out   <= w_s;
            o_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        o_out   <= 1'b1;
                        o_busy  <= 1'b1;
                    end else begin
                        o_out   <= w_s;
                        o_busy  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_edge && (i_retrig || w_expire)) begin
                        r_cnt   <= '0;
                        o_out   <= 1'b1;
                        o_busy  <= 1'b1;
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        o_out   <= w_s;
                        o_busy  <= 1'b0;
                    end else begin
                        if (i_tick) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        o_out   <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    o_out   <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stretch_multi.sv
// Multi-channel pulse stretcher: one free-running prescaler shared by
// CHANNELS independent stretch channels.
module stretch_multi #(
    parameter int CHANNELS    = 4,
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_TICKS  = 250,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [1:0]          mode,
    input  logic                retrig,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic          w_tick;

    // With TICK_DIV=1 the counter sits at 0 and the tick is permanently high.
    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        stretch_chan #(
            .HOLD_TICKS  (HOLD_TICKS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_in     (in[g]),
            .i_tick   (w_tick),
            .i_mode   (mode),
            .i_retrig (retrig),
            .o_out    (out[g]),
            .o_busy   (busy[g])
        );
    end

endmodule
